// File: rtl/tpu_c_reader.sv
// Drains the C accumulators of the DIM x DIM MAC array onto a valid/ready stream.
// Latency: start accepted at edge N -> first beat valid after edge N+1 (seen at N+2);
//          one SEL cycle per row, then one beat per accepted handshake.
// Backpressure: out_ready low stalls the beat; data/row/col hold and out_valid stays high.
//
// Optional feature macro: TPU_C_READER_SAT_EN
//   defined   -> out_data is the signed saturation of the accumulator to BITS_OUT bits,
//                and the extra output sat_flag marks clamped beats.
//   undefined -> out_data is the two's-complement truncation (low BITS_OUT bits).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                begin a full-array drain (only honoured in IDLE)
//   c_row_in             DIM accumulators of the selected row, column c at [c*BITS_C +: BITS_C]
//   row_sel              row select to the array read mux
//   out_valid/out_ready  output stream handshake
//   out_data             converted result word
//   out_row/out_col      array coordinates of the current beat
//   busy                 high whenever not IDLE
//   sat_flag             (macro only) beat value was clamped
//   done                 one-cycle pulse after the last beat is accepted
module tpu_c_reader #(
    parameter int BITS_C   = 16,
    parameter int BITS_OUT = 8,
    parameter int DIM      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DIM*BITS_C-1:0]  c_row_in,
    output logic [$clog2(DIM)-1:0] row_sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BITS_OUT-1:0]    out_data,
    output logic [$clog2(DIM)-1:0] out_row,
    output logic [$clog2(DIM)-1:0] out_col,
    output logic                   busy,
`ifdef TPU_C_READER_SAT_EN
    output logic                   sat_flag,
`endif
    output logic                   done
);

    localparam int            RW   = $clog2(DIM);
    localparam logic [RW-1:0] LAST = RW'(DIM - 1);

    typedef enum logic [1:0] {IDLE, SEL, STREAM, DONE} state_t;

    state_t              state_q;
    logic [RW-1:0]       row_q;
    logic [RW-1:0]       col_q;
    logic [RW-1:0]       row_d;
    logic [RW-1:0]       col_d;
    logic [BITS_C-1:0]   buf_q [DIM];
    logic                out_valid_q;
    logic [BITS_OUT-1:0] out_data_q;
    logic                busy_q;
    logic                done_q;
    logic                hs;

    assign row_d = row_q + RW'(1);
    assign col_d = col_q + RW'(1);
    assign hs    = out_valid_q & out_ready;

`ifdef TPU_C_READER_SAT_EN
    localparam logic signed [BITS_C-1:0] SAT_MAX = BITS_C'((1 << (BITS_OUT - 1)) - 1);
    localparam logic signed [BITS_C-1:0] SAT_MIN = ~SAT_MAX;

    logic sat_flag_q;

    function automatic logic [BITS_OUT-1:0] conv(input logic [BITS_C-1:0] w);
        logic signed [BITS_C-1:0] s;
        s = $signed(w);
        if (s > SAT_MAX) begin
            s = SAT_MAX;
        end else if (s < SAT_MIN) begin
            s = SAT_MIN;
        end
        return BITS_OUT'(s);
    endfunction

    function automatic logic clamped(input logic [BITS_C-1:0] w);
        return ($signed(w) > SAT_MAX) || ($signed(w) < SAT_MIN);
    endfunction

    assign sat_flag = sat_flag_q;
`else
    function automatic logic [BITS_OUT-1:0] conv(input logic [BITS_C-1:0] w);
        return BITS_OUT'(w);
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int c = 0; c < DIM; c++) begin
                buf_q[c] <= '0;
            end
`ifdef TPU_C_READER_SAT_EN
            sat_flag_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SEL;
                        row_q   <= '0;
                        col_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SEL: begin
                    // Whole row captured at once; beat 0 is preloaded so the
                    // stream starts on the very next cycle.
                    for (int c = 0; c < DIM; c++) begin
                        buf_q[c] <= c_row_in[c*BITS_C +: BITS_C];
                    end
                    out_data_q  <= conv(c_row_in[0 +: BITS_C]);
`ifdef TPU_C_READER_SAT_EN
                    sat_flag_q  <= clamped(c_row_in[0 +: BITS_C]);
`endif
                    out_valid_q <= 1'b1;
                    state_q     <= STREAM;
                end
                STREAM: begin
                    if (hs) begin
                        if (col_q != LAST) begin
                            col_q      <= col_d;
                            out_data_q <= conv(buf_q[col_d]);
`ifdef TPU_C_READER_SAT_EN
                            sat_flag_q <= clamped(buf_q[col_d]);
`endif
                        end else begin
                            out_valid_q <= 1'b0;
`ifdef TPU_C_READER_SAT_EN
                            sat_flag_q  <= 1'b0;
`endif
                            if (row_q != LAST) begin
                                row_q   <= row_d;
                                col_q   <= '0;
                                state_q <= SEL;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    row_q   <= '0;
                    col_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The row counter only moves on entry to SEL or on return to IDLE,
    // so it doubles as the array read select.
    assign row_sel   = row_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_tpu_c_reader.sv
module tb_tpu_c_reader;

    localparam int BITS_C   = 16;
    localparam int BITS_OUT = 8;
    localparam int DIM      = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start;
    logic [DIM*BITS_C-1:0]  c_row_in;
    logic [1:0]             row_sel;
    logic                   out_valid;
    logic                   out_ready;
    logic [BITS_OUT-1:0]    out_data;
    logic [1:0]             out_row;
    logic [1:0]             out_col;
    logic                   busy;
    logic                   done;
`ifdef TPU_C_READER_SAT_EN
    logic                   sat_flag;
`endif

    tpu_c_reader #(.BITS_C(BITS_C), .BITS_OUT(BITS_OUT), .DIM(DIM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .c_row_in  (c_row_in),
        .row_sel   (row_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .busy      (busy),
`ifdef TPU_C_READER_SAT_EN
        .sat_flag  (sat_flag),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [1:0] r;
        logic [1:0] c;
        logic       s;
    } beat_t;

    beat_t exp_q[$];
    int    c_mat [DIM][DIM];
    int    nchecks = 0;
    int    nerr    = 0;
    int    done_cnt = 0;
    int    ready_mode = 0;
    int    tick = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference conversion from plain integer arithmetic.
    function automatic logic [7:0] model_conv(input int v);
`ifdef TPU_C_READER_SAT_EN
        if (v > 127)  return 8'h7F;
        if (v < -128) return 8'h80;
`endif
        return 8'(v);
    endfunction

    function automatic logic model_sat(input int v);
`ifdef TPU_C_READER_SAT_EN
        return (v > 127) || (v < -128);
`else
        return 1'b0;
`endif
    endfunction

    // Array read mux model; while the reader is streaming the row bus carries
    // garbage so that anything not captured at the end of SEL shows up.
    always @(posedge clk) begin
        #2;
        for (int c = 0; c < DIM; c++) begin
            c_row_in[c*BITS_C +: BITS_C] = out_valid ? 16'($urandom) : 16'(c_mat[row_sel][c]);
        end
    end

    always @(posedge clk) begin
        #1;
        tick++;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (tick % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor / scoreboard
    logic       stall_p = 0, gap_p = 0, rise_p = 0, dn_p = 0, dnf_p = 0;
    logic [7:0] st_d;
    logic [1:0] st_r, st_c, gap_row;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_p = 0; gap_p = 0; rise_p = 0; dn_p = 0; dnf_p = 0;
        end else begin
            if (stall_p) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, st_d);
                chk("stall_row", out_row, st_r);
                chk("stall_col", out_col, st_c);
            end
            if (rise_p) chk("row_valid_rise", out_valid, 1);
            if (dnf_p) begin
                chk("done_fall", done, 0);
                chk("idle_busy", busy, 0);
            end
            rise_p = 0; dnf_p = 0;
            if (gap_p) begin
                chk("sel_gap_valid", out_valid, 0);
                chk("sel_row_sel", row_sel, gap_row);
                rise_p = 1;
            end
            if (dn_p) begin
                chk("done_pulse", done, 1);
                chk("done_valid", out_valid, 0);
                dnf_p = 1;
            end
            gap_p = 0; dn_p = 0;
            if (done) done_cnt++;
            stall_p = out_valid && !out_ready;
            if (stall_p) begin
                st_d = out_data; st_r = out_row; st_c = out_col;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    nchecks++;
                    nerr++;
                    $display("FAIL unexpected_beat: got row %0d col %0d data %0h, expected no beat",
                             out_row, out_col, out_data);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", out_data, e.d);
                    chk("beat_row", out_row, e.r);
                    chk("beat_col", out_col, e.c);
`ifdef TPU_C_READER_SAT_EN
                    chk("beat_sat", sat_flag, e.s);
`endif
                    if (e.c == 2'(DIM - 1)) begin
                        if (e.r == 2'(DIM - 1)) dn_p = 1;
                        else begin
                            gap_p = 1;
                            gap_row = e.r + 2'd1;
                        end
                    end
                end
            end
        end
    end

    task automatic push_expected();
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                beat_t b;
                b.d = model_conv(c_mat[r][c]);
                b.r = 2'(r);
                b.c = 2'(c);
                b.s = model_sat(c_mat[r][c]);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_drain(input int mode, input bit repulse);
        int base;
        ready_mode = mode;
        base = done_cnt;
        push_expected();
        pulse_start();
        @(negedge clk);
        chk("lat_sel_valid", out_valid, 0);
        chk("lat_sel_busy", busy, 1);
        @(negedge clk);
        chk("lat_first_valid", out_valid, 1);
        if (repulse) begin
            for (int i = 0; i < 300 && !(out_valid && out_row == 2'd1); i++) @(negedge clk);
            chk("reach_row1", out_row, 1);
            pulse_start();
        end
        for (int i = 0; i < 1000 && done_cnt == base; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("done_count", done_cnt - base, 1);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_row_sel", row_sel, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_col", out_col, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
`ifdef TPU_C_READER_SAT_EN
        chk("rst_sat_flag", sat_flag, 0);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0;
        start = 1'b0;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) c_mat[r][c] = r * 16 + c;
        #3;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs();

        // Incrementing pattern, ready held high
        run_drain(0, 1'b0);
        // Same pattern with ready stalls
        run_drain(1, 1'b0);
        // start re-pulsed during row 1 is ignored
        run_drain(1, 1'b1);

        // Conversion corner values
        c_mat[0][1] = 300;
        c_mat[1][2] = -200;
        c_mat[2][3] = 5;
        c_mat[3][0] = -128;
        c_mat[3][3] = 127;
        run_drain(0, 1'b0);

        // Randomized arrays and randomized backpressure
        for (int n = 0; n < 4; n++) begin
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++)
                    c_mat[r][c] = (n == 0) ? $urandom_range(0, 300) - 150 : int'(16'($urandom)) - 32768;
            run_drain(2, 1'b0);
        end

        // Reset in the middle of row 2
        ready_mode = 0;
        base = done_cnt;
        push_expected();
        pulse_start();
        for (int i = 0; i < 300 && !(out_valid && out_row == 2'd2); i++) @(negedge clk);
        chk("reach_row2", out_row, 2);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_no_done", done_cnt - base, 0);
        check_reset_outputs();
        // Fresh drain after reset starts again at row 0, col 0
        run_drain(2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/tpu_c_reader.md
Name: tpu_c_reader

Overview:
- Drains accumulated C results out of the systolic MAC array after a matrix multiply completes.
- Selects one array row at a time and captures its DIM accumulator values in a single cycle.
- Serializes the captured values onto a valid/ready stream, one word per beat, in row-major order.
- Sits between the MAC array outputs and the result memory/host interface. It is the read-out counterpart of the Cin/WrEn load path.

Parameters:
- BITS_C, 16, width of each MAC accumulator value.
- BITS_OUT, 8, width of the streamed output word. Must be ≤ BITS_C.
- DIM, 8, array dimension: DIM rows × DIM columns. Must be ≥ 2.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin a full-array drain. Sampled only in IDLE.
- c_row_in  input  DIM*BITS_C  signed accumulator values of the selected row. Column c occupies bits [c*BITS_C +: BITS_C].
- row_sel  output  $clog2(DIM)  row select driven to the array read mux
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts the beat
- out_data  output  BITS_OUT  signed result word
- out_row  output  $clog2(DIM)  row index of the current beat
- out_col  output  $clog2(DIM)  column index of the current beat
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset values (asynchronous): state=IDLE, row_sel=0, out_valid=0, out_data=0, out_row=0, out_col=0, busy=0, done=0. The capture buffer is cleared to 0.
- IDLE:
  - start=1 → go to SEL with row counter=0 and col counter=0.
  - start=0 → stay in IDLE.
- SEL (1 cycle):
  - row_sel = row counter.
  - At the closing clock edge, all DIM words of c_row_in are captured into the buffer.
  - Go to STREAM.
- STREAM:
  - out_valid=1.
  - out_data = converted buffer[col]; out_row = row counter; out_col = col counter.
  - Handshake occurs when out_valid & out_ready.
  - Handshake with col<DIM-1 → col+1, stay in STREAM.
  - Handshake with col=DIM-1 and row<DIM-1 → row+1, col=0, go to SEL. out_valid is 0 during SEL.
  - Handshake with col=DIM-1 and row=DIM-1 → go to DONE.
  - While out_ready=0: out_data, out_row and out_col hold stable and out_valid stays 1. out_valid never drops without a handshake.
- DONE (1 cycle): done=1, then go to IDLE. row_sel returns to 0.
- row_sel holds its value through STREAM. It changes only when entering SEL or returning to IDLE.
- Latency:
  - start accepted at edge N → first out_valid at edge N+2.
  - With out_ready held high, a full drain takes DIM*(DIM+1) cycles from entering SEL to entering DONE.
- start asserted while busy is ignored. No queuing.
- start asserted in the DONE cycle is ignored. A new drain requires start in IDLE.
- Conversion without the optional feature: out_data = buffer word[BITS_OUT-1:0], i.e. two's-complement truncation. When BITS_OUT = BITS_C this is an identity pass-through.
- Reset mid-operation: reset immediately returns all state to the reset values. A partial drain is abandoned and no done pulse is generated.
- c_row_in is sampled only at the end of SEL. Changes to it during STREAM have no effect.

Optional Feature:
- Macro: TPU_C_READER_SAT_EN.
- Defined: out_data is the signed saturation of the buffer word to BITS_OUT bits.
  - Values > 2^(BITS_OUT-1)-1 clamp to the max.
  - Values < -2^(BITS_OUT-1) clamp to the min.
  - An additional output port sat_flag (1 bit) is high alongside any beat whose value was clamped. It is 0 otherwise and 0 at reset.
- Undefined: truncation as described above. The sat_flag port does not exist.

Test Plan:
1. DIM=4, BITS_C=16, BITS_OUT=16, array row r col c holds r*16+c, out_ready tied 1, pulse start → 16 beats with out_data 0,1,2,3,16,...,51, matching out_row/out_col. out_valid is low for exactly one SEL cycle between rows. done pulses once, 1 cycle after the last beat.
2. Same setup, out_ready toggling 1,0,0,1,… → out_data/out_row/out_col stable during stalls, no beat lost or duplicated, same 16-value sequence.
3. start re-pulsed mid-drain (during row 1) → ignored. The sequence continues unchanged and a single done pulse is produced.
4. rst_n asserted during row 2 of a drain → next cycle shows all outputs at reset values. A fresh start then drains from row 0, col 0.
5. BITS_OUT=8, a cell holding 300 (0x012C) and a cell holding -200:
   - Without the macro → out_data 0x2C and 0x38.
   - With TPU_C_READER_SAT_EN → out_data 127 and -128 with sat_flag=1. A cell holding 5 → 5 with sat_flag=0.
6. c_row_in changed during STREAM of row 0 → streamed row-0 values reflect only the values captured at the end of SEL.
